seq_divider: RTL and testbench

Multi-cycle unsigned restoring divider, the subtractive counterpart of the datapath's carry lookahead adder. It produces one quotient bit per clock using a Width+1-bit trial subtraction (add of the inverted divisor with carry-in 1). It sits beside the adder in the arithmetic datapath and uses a start/busy/done handshake so that a controller can issue one division at a time.

---
 rtl/seq_divider.sv | 92 +++++++++
 tb/tb_seq_divider.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider producing one quotient bit per clock
module seq_divider #(
    parameter int Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [Width-1:0] dividend,
    input  logic [Width-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] quotient,
    output logic [Width-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(Width + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;
    logic [Width-1:0] q_q, q_d, r_q, r_d, d_q, d_d, quot_q, quot_d, rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic dbz_q, dbz_d;
    logic [Width:0] s, t;
    logic nb;
    always_comb begin
        s = {r_q, q_q[Width-1]};
        // partial remainder stays below D, so t[Width] is the sign of S - D
        t = s + ~{1'b0, d_q} + {{Width{1'b0}}, 1'b1};
        nb = ~t[Width];
        state_d = state_q;
        q_d = q_q;
        r_d = r_q;
        d_d = d_q;
        cnt_d = cnt_q;
        quot_d = quot_q;
        rem_d = rem_q;
        dbz_d = dbz_q;
        case (state_q)
            IDLE: begin
                if (start && divisor == '0) begin
                    quot_d = '1;
                    rem_d = dividend;
                    dbz_d = 1'b1;
                    state_d = DONE;
                end else if (start) begin
                    q_d = dividend;
                    r_d = '0;
                    d_d = divisor;
                    cnt_d = CW'(Width);
                    state_d = CALC;
                end
            end
            CALC: begin
                q_d = {q_q[Width-2:0], nb};
                r_d = nb ? t[Width-1:0] : s[Width-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d = q_d;
                    rem_d = r_d;
                    dbz_d = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q <= '0;
            r_q <= '0;
            d_q <= '0;
            cnt_q <= '0;
            quot_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q <= q_d;
            r_q <= r_d;
            d_q <= d_d;
            cnt_q <= cnt_d;
            quot_q <= quot_d;
            rem_q <= rem_d;
            dbz_q <= dbz_d;
        end
    end
    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign quotient = quot_q;
    assign remainder = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table, hand-sequenced and randomized checks of seq_divider at widths 4, 8 and 16
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic st4, bz4, dn4, dz4;
    logic [3:0] a4, b4, q4, r4;
    logic st8, bz8, dn8, dz8;
    logic [7:0] a8, b8, q8, r8;
    logic st16, bz16, dn16, dz16;
    logic [15:0] a16, b16, q16, r16;
    int vectors = 0;
    int miscompares = 0;
    seq_divider #(.Width(4)) u4 (.clk(clk), .rst_n(rst_n), .start(st4), .dividend(a4), .divisor(b4),
        .busy(bz4), .done(dn4), .quotient(q4), .remainder(r4), .div_by_zero(dz4));
    seq_divider #(.Width(8)) u8 (.clk(clk), .rst_n(rst_n), .start(st8), .dividend(a8), .divisor(b8),
        .busy(bz8), .done(dn8), .quotient(q8), .remainder(r8), .div_by_zero(dz8));
    seq_divider #(.Width(16)) u16 (.clk(clk), .rst_n(rst_n), .start(st16), .dividend(a16), .divisor(b16),
        .busy(bz16), .done(dn16), .quotient(q16), .remainder(r16), .div_by_zero(dz16));
    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dz;
        int lat;
        int bc;
    } vec_t;
    vec_t tbl [7];
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic set_in(input int w, input logic s, input int a, input int b);
        case (w)
            4: begin st4 = s; a4 = 4'(a); b4 = 4'(b); end
            8: begin st8 = s; a8 = 8'(a); b8 = 8'(b); end
            default: begin st16 = s; a16 = 16'(a); b16 = 16'(b); end
        endcase
    endtask
    task automatic get(input int w, output int q, output int r, output int dz, output int bz, output int dn);
        case (w)
            4: begin q = int'(q4); r = int'(r4); dz = int'(dz4); bz = int'(bz4); dn = int'(dn4); end
            8: begin q = int'(q8); r = int'(r8); dz = int'(dz8); bz = int'(bz8); dn = int'(dn8); end
            default: begin q = int'(q16); r = int'(r16); dz = int'(dz16); bz = int'(bz16); dn = int'(dn16); end
        endcase
    endtask
    task automatic wait_done(input int w, output int lat, output int bc);
        int q, r, dz, bz, dn;
        lat = 0;
        bc = 0;
        dn = 0;
        while (dn == 0 && lat < 64) begin
            @(negedge clk);
            lat++;
            get(w, q, r, dz, bz, dn);
            bc += bz;
        end
    endtask
    task automatic do_div(input int w, input int a, input int b,
                          output int q, output int r, output int dz, output int lat, output int bc);
        int bz, dn;
        @(negedge clk);
        set_in(w, 1'b1, a, b);
        @(posedge clk);
        #1 set_in(w, 1'b0, a, b);
        wait_done(w, lat, bc);
        get(w, q, r, dz, bz, dn);
    endtask
    task automatic run_case(input int w, input int a, input int b, input string tag);
        int q, r, dz, lat, bc, eq, er;
        string n;
        do_div(w, a, b, q, r, dz, lat, bc);
        n = $sformatf("%s w%0d %0d/%0d", tag, w, a, b);
        if (b == 0) begin
            eq = (1 << w) - 1;
            er = a;
        end else begin
            eq = a / b;
            er = a % b;
        end
        check({n, " q"}, q, eq);
        check({n, " r"}, r, er);
        check({n, " dz"}, dz, int'(b == 0));
        check({n, " latency"}, lat, (b == 0) ? 1 : w + 1);
        check({n, " busy_cycles"}, bc, (b == 0) ? 0 : w);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        int q, r, dz, bz, dn, lat, bc, cnt, a, b;
        tbl[0] = '{13, 3, 4, 1, 0, 5, 4};
        tbl[1] = '{15, 1, 15, 0, 0, 5, 4};
        tbl[2] = '{5, 7, 0, 5, 0, 5, 4};
        tbl[3] = '{15, 15, 1, 0, 0, 5, 4};
        tbl[4] = '{0, 9, 0, 0, 0, 5, 4};
        tbl[5] = '{9, 0, 15, 9, 1, 1, 0};
        tbl[6] = '{8, 2, 4, 0, 0, 5, 4};
        set_in(4, 1'b0, 0, 0);
        set_in(8, 1'b0, 0, 0);
        set_in(16, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        get(4, q, r, dz, bz, dn);
        check("reset q", q, 0);
        check("reset r", r, 0);
        check("reset dz", dz, 0);
        check("reset busy", bz, 0);
        check("reset done", dn, 0);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            do_div(4, tbl[i].a, tbl[i].b, q, r, dz, lat, bc);
            check($sformatf("tbl%0d q", i), q, tbl[i].q);
            check($sformatf("tbl%0d r", i), r, tbl[i].r);
            check($sformatf("tbl%0d dz", i), dz, tbl[i].dz);
            check($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
            check($sformatf("tbl%0d busy_cycles", i), bc, tbl[i].bc);
        end
        @(negedge clk);
        set_in(4, 1'b1, 13, 3);
        @(posedge clk);
        #1 set_in(4, 1'b1, 14, 5);
        wait_done(4, lat, bc);
        get(4, q, r, dz, bz, dn);
        check("held first q", q, 4);
        check("held first r", r, 1);
        check("held first latency", lat, 5);
        wait_done(4, lat, bc);
        set_in(4, 1'b0, 14, 5);
        get(4, q, r, dz, bz, dn);
        check("held second done", dn, 1);
        check("held second q", q, 2);
        check("held second r", r, 4);
        @(negedge clk);
        get(4, q, r, dz, bz, dn);
        check("held idle busy", bz, 0);
        check("held idle done", dn, 0);
        do_div(4, 6, 2, q, r, dz, lat, bc);
        check("dstart q", q, 3);
        check("dstart latency", lat, 5);
        set_in(4, 1'b1, 15, 1);
        @(posedge clk);
        #1 set_in(4, 1'b0, 15, 1);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            get(4, q, r, dz, bz, dn);
            cnt += bz + dn;
        end
        check("dstart ignored activity", cnt, 0);
        check("dstart q held", q, 3);
        @(negedge clk);
        set_in(4, 1'b1, 14, 3);
        @(posedge clk);
        #1 set_in(4, 1'b0, 14, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 get(4, q, r, dz, bz, dn);
        check("midrst q", q, 0);
        check("midrst r", r, 0);
        check("midrst dz", dz, 0);
        check("midrst busy", bz, 0);
        check("midrst done", dn, 0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            get(4, q, r, dz, bz, dn);
            cnt += bz + dn;
        end
        check("midrst activity", cnt, 0);
        rst_n = 1'b1;
        run_case(4, 14, 3, "post_rst");
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                run_case(4, x, y, "exh");
        run_case(8, 200, 0, "rnd");
        run_case(8, 255, 1, "rnd");
        repeat (60) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            run_case(8, a, b, "rnd");
        end
        run_case(16, 65535, 0, "rnd");
        run_case(16, 65535, 65535, "rnd");
        repeat (40) begin
            a = int'($urandom_range(0, 65535));
            b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 65535));
            run_case(16, a, b, "rnd");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
